// File: rtl/mem_timing_pkg.sv
// Shared encodings and helpers for the LSU memory-timing path.
package mem_timing_pkg;

  localparam int SIZE_COUNT   = 16;
  localparam int SIZE_RAM_LOG = 5;

  localparam logic [1:0] MT_L1     = 2'd0;
  localparam logic [1:0] MT_L2     = 2'd1;
  localparam logic [1:0] MT_DRAM   = 2'd2;
  localparam logic [1:0] MT_SHARED = 2'd3;

  // An out-time of all ones marks an empty FIFO head, so no real entry may carry it.
  localparam logic [SIZE_COUNT-1:0] MT_SENTINEL = '1;

  function automatic int mt_latency(input logic [1:0] cls, input int lat_l1,
                                    input int lat_l2, input int lat_dram,
                                    input int lat_shared);
    case (cls)
      MT_L1:   return lat_l1;
      MT_L2:   return lat_l2;
      MT_DRAM: return lat_dram;
      default: return lat_shared;
    endcase
  endfunction

endpackage

// File: rtl/mem_latency_enqueue_ts_fifo.sv
// Single-class timestamped FIFO; head fields are read from storage at the read pointer,
// and an empty FIFO shows an all-ones out-time with zeroed payload.
module ts_fifo #(
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3,
  parameter int W_TIME    = 16,
  parameter int W_ADDR    = 32,
  parameter int W_RAM     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [W_TIME-1:0] out_time_i,
  input  logic [W_TIME-1:0] in_time_i,
  input  logic [W_ADDR-1:0] addr_i,
  input  logic [W_RAM-1:0]  ram_addr_i,
  output logic [W_TIME-1:0] out_time_o,
  output logic [W_TIME-1:0] in_time_o,
  output logic [W_ADDR-1:0] addr_o,
  output logic [W_RAM-1:0]  ram_addr_o,
  output logic              empty_o,
  output logic              full_o
);

  typedef struct packed {
    logic [W_TIME-1:0] out_time;
    logic [W_TIME-1:0] in_time;
    logic [W_ADDR-1:0] addr;
    logic [W_RAM-1:0]  ram_addr;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   cnt_q, cnt_d;
  logic                 do_push, do_pop;
  entry_t               head;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (DEPTH_LOG+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{out_time_i, in_time_i, addr_i, ram_addr_i};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_time_o = empty_o ? '1 : head.out_time;
  assign in_time_o  = empty_o ? '0 : head.in_time;
  assign addr_o     = empty_o ? '0 : head.addr;
  assign ram_addr_o = empty_o ? '0 : head.ram_addr;

endmodule

// File: rtl/mem_latency_enqueue.sv
// Write side of the per-class latency FIFOs: classify, timestamp and enqueue LSU
// requests; expose each class head to the time-check arbiter and pop on its grant.
module mem_latency_enqueue
  import mem_timing_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DEPTH_LOG    = 3,
  parameter int SIZE_ADDR    = 32,
  parameter int SIZE_RAM_LOG = mem_timing_pkg::SIZE_RAM_LOG,
  parameter int SIZE_COUNT   = mem_timing_pkg::SIZE_COUNT,
  parameter int LAT_L1       = 4,
  parameter int LAT_L2       = 20,
  parameter int LAT_DRAM     = 100,
  parameter int LAT_SHARED   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [SIZE_COUNT-1:0]     count,
  input  logic                      req_valid,
  input  logic [1:0]                req_type,
  input  logic [SIZE_ADDR-1:0]      req_addr,
  input  logic [SIZE_RAM_LOG-1:0]   req_ram_addr,
  output logic                      req_ready,
  input  logic                      pop_valid,
  input  logic [1:0]                pop_type,
  output logic [4*SIZE_COUNT-1:0]   head_out_time,
  output logic [4*SIZE_COUNT-1:0]   head_in_time,
  output logic [4*SIZE_ADDR-1:0]    head_addr,
  output logic [4*SIZE_RAM_LOG-1:0] head_ram_addr,
  output logic [3:0]                empty,
  output logic [3:0]                full,
  output logic                      pop_err
);

  localparam logic [SIZE_COUNT-1:0] SENTINEL = {SIZE_COUNT{1'b1}};

  logic                  push_fire, pop_fire;
  logic [SIZE_COUNT-1:0] lat, out_sum, out_time;
  logic                  pop_err_q, pop_err_d;

  assign req_ready = ~full[req_type] & ~stall;
  assign push_fire = req_valid & req_ready;
  assign pop_fire  = pop_valid & ~stall;

  assign lat      = SIZE_COUNT'(mt_latency(req_type, LAT_L1, LAT_L2, LAT_DRAM, LAT_SHARED));
  assign out_sum  = count + lat;
  // Pulling a sentinel-valued deadline one cycle early keeps it distinguishable from empty.
  assign out_time = (out_sum == SENTINEL) ? SENTINEL - 1'b1 : out_sum;

  always_comb begin
    pop_err_d = pop_err_q;
    if (pop_fire && empty[pop_type]) pop_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pop_err_q <= 1'b0;
    else       pop_err_q <= pop_err_d;
  end

  assign pop_err = pop_err_q;

  for (genvar k = 0; k < 4; k++) begin : g_cls
    ts_fifo #(
      .DEPTH    (DEPTH),
      .DEPTH_LOG(DEPTH_LOG),
      .W_TIME   (SIZE_COUNT),
      .W_ADDR   (SIZE_ADDR),
      .W_RAM    (SIZE_RAM_LOG)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push_fire && (req_type == 2'(k))),
      .pop_i     (pop_fire && (pop_type == 2'(k))),
      .out_time_i(out_time),
      .in_time_i (count),
      .addr_i    (req_addr),
      .ram_addr_i(req_ram_addr),
      .out_time_o(head_out_time[k*SIZE_COUNT +: SIZE_COUNT]),
      .in_time_o (head_in_time[k*SIZE_COUNT +: SIZE_COUNT]),
      .addr_o    (head_addr[k*SIZE_ADDR +: SIZE_ADDR]),
      .ram_addr_o(head_ram_addr[k*SIZE_RAM_LOG +: SIZE_RAM_LOG]),
      .empty_o   (empty[k]),
      .full_o    (full[k])
    );
  end

endmodule

// File: tb/tb_mem_latency_enqueue.sv
// Directed bench for mem_latency_enqueue with hand-computed expectations.
module tb_mem_latency_enqueue;

  logic        clk = 1'b0;
  logic        reset, stall, req_valid, req_ready, pop_valid, pop_err;
  logic [15:0] count;
  logic [1:0]  req_type, pop_type;
  logic [31:0] req_addr;
  logic [4:0]  req_ram_addr;
  logic [63:0] head_out_time, head_in_time;
  logic [127:0] head_addr;
  logic [19:0] head_ram_addr;
  logic [3:0]  empty, full;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_latency_enqueue dut (
    .clk(clk), .reset(reset), .stall(stall), .count(count),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .req_ram_addr(req_ram_addr), .req_ready(req_ready),
    .pop_valid(pop_valid), .pop_type(pop_type),
    .head_out_time(head_out_time), .head_in_time(head_in_time),
    .head_addr(head_addr), .head_ram_addr(head_ram_addr),
    .empty(empty), .full(full), .pop_err(pop_err)
  );

  function automatic logic [15:0] hot(input int k);
    return head_out_time[k*16 +: 16];
  endfunction
  function automatic logic [15:0] hit(input int k);
    return head_in_time[k*16 +: 16];
  endfunction
  function automatic logic [31:0] had(input int k);
    return head_addr[k*32 +: 32];
  endfunction
  function automatic logic [4:0] hram(input int k);
    return head_ram_addr[k*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; req_valid = 0; req_type = 0; req_addr = 0; req_ram_addr = 0;
    pop_valid = 0; pop_type = 0; count = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [4:0] r,
                      input logic [15:0] c);
    req_valid = 1; req_type = t; req_addr = a; req_ram_addr = r; count = c;
    step();
    req_valid = 0;
  endtask

  task automatic pop(input logic [1:0] t);
    pop_valid = 1; pop_type = t;
    step();
    pop_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (empty !== 4'hF) begin fails++; $display("FAIL reset_empty: got %h want f", empty); end
    tests++; if (full !== 4'h0) begin fails++; $display("FAIL reset_full: got %h want 0", full); end
    tests++; if (pop_err !== 1'b0) begin fails++; $display("FAIL reset_pop_err: got %b want 0", pop_err); end
    tests++; if (head_out_time !== {64{1'b1}}) begin fails++; $display("FAIL reset_out_time: got %h want all ones", head_out_time); end
    tests++; if (head_in_time !== '0 || head_addr !== '0 || head_ram_addr !== '0) begin
      fails++; $display("FAIL reset_heads: in %h addr %h ram %h want 0", head_in_time, head_addr, head_ram_addr);
    end
  endtask

  task automatic test_dram_push();
    do_reset();
    push(2'd2, 32'h1000, 5'd3, 16'd50);
    tests++; if (empty[2] !== 1'b0) begin fails++; $display("FAIL dram_empty: got %b want 0", empty[2]); end
    tests++; if (hot(2) !== 16'd150) begin fails++; $display("FAIL dram_out_time: got %0d want 150", hot(2)); end
    tests++; if (hit(2) !== 16'd50) begin fails++; $display("FAIL dram_in_time: got %0d want 50", hit(2)); end
    tests++; if (hram(2) !== 5'd3) begin fails++; $display("FAIL dram_ram: got %0d want 3", hram(2)); end
    tests++; if (had(2) !== 32'h1000) begin fails++; $display("FAIL dram_addr: got %h want 1000", had(2)); end
    tests++; if (empty !== 4'b1011) begin fails++; $display("FAIL dram_other_empty: got %b want 1011", empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    push(2'd0, 32'h10, 5'd1, 16'hFFFE);
    tests++; if (hot(0) !== 16'h0002) begin fails++; $display("FAIL wrap_l1: got %h want 0002", hot(0)); end
    push(2'd2, 32'h20, 5'd2, 16'hFF9B);
    tests++; if (hot(2) !== 16'hFFFE) begin fails++; $display("FAIL sentinel_clamp: got %h want fffe", hot(2)); end
    tests++; if (hit(2) !== 16'hFF9B) begin fails++; $display("FAIL clamp_in_time: got %h want ff9b", hit(2)); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push(2'd1, 32'h200 + i, 5'(i), 16'(i));
    tests++; if (full !== 4'b0010) begin fails++; $display("FAIL full_flags: got %b want 0010", full); end
    tests++; if (hot(1) !== 16'd20) begin fails++; $display("FAIL l2_out_time: got %0d want 20", hot(1)); end
    req_valid = 1; req_type = 2'd1; req_addr = 32'hDEAD; count = 16'd9;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_full: got %b want 0", req_ready); end
    req_type = 2'd0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_other: got %b want 1", req_ready); end
    req_type = 2'd1;
    step();
    req_valid = 0;
    pop(2'd1);
    tests++; if (full[1] !== 1'b0) begin fails++; $display("FAIL full_after_pop: got %b want 0", full[1]); end
    tests++; if (had(1) !== 32'h201 || hot(1) !== 16'd21) begin
      fails++; $display("FAIL head_advance: got addr %h out %0d want 201 21", had(1), hot(1));
    end
    for (int i = 2; i < 8; i++) begin
      pop(2'd1);
      tests++; if (had(1) !== 32'h200 + i) begin fails++; $display("FAIL l2_order: got %h want %h", had(1), 32'h200 + i); end
    end
    pop(2'd1);
    tests++; if (empty[1] !== 1'b1) begin fails++; $display("FAIL l2_drained: got %b want 1", empty[1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(2'd3, 32'hA, 5'd10, 16'd100);
    push(2'd3, 32'hB, 5'd11, 16'd101);
    push(2'd3, 32'hC, 5'd12, 16'd102);
    tests++; if (hot(3) !== 16'd102) begin fails++; $display("FAIL shared_out_time: got %0d want 102", hot(3)); end
    pop_valid = 1; pop_type = 2'd3;
    push(2'd3, 32'hD, 5'd13, 16'd103);
    pop_valid = 0;
    tests++; if (had(3) !== 32'hB) begin fails++; $display("FAIL bb_head_b: got %h want b", had(3)); end
    pop(2'd3);
    tests++; if (had(3) !== 32'hC) begin fails++; $display("FAIL bb_head_c: got %h want c", had(3)); end
    pop(2'd3);
    tests++; if (had(3) !== 32'hD || hot(3) !== 16'd105) begin
      fails++; $display("FAIL bb_head_d: got addr %h out %0d want d 105", had(3), hot(3));
    end
    pop(2'd3);
    tests++; if (empty[3] !== 1'b1 || hot(3) !== 16'hFFFF) begin
      fails++; $display("FAIL bb_drained: got empty %b out %h want 1 ffff", empty[3], hot(3));
    end
  endtask

  task automatic test_pop_err();
    do_reset();
    pop(2'd0);
    tests++; if (pop_err !== 1'b1) begin fails++; $display("FAIL pop_err_set: got %b want 1", pop_err); end
    tests++; if (empty !== 4'hF) begin fails++; $display("FAIL pop_err_empty: got %b want 1111", empty); end
    push(2'd0, 32'h55, 5'd7, 16'd7);
    tests++; if (had(0) !== 32'h55 || hot(0) !== 16'd11) begin
      fails++; $display("FAIL pop_err_ptr: got addr %h out %0d want 55 11", had(0), hot(0));
    end
    step(); step();
    tests++; if (pop_err !== 1'b1) begin fails++; $display("FAIL pop_err_sticky: got %b want 1", pop_err); end
    do_reset();
    tests++; if (pop_err !== 1'b0) begin fails++; $display("FAIL pop_err_clear: got %b want 0", pop_err); end
  endtask

  task automatic test_stall();
    do_reset();
    push(2'd2, 32'h77, 5'd4, 16'd10);
    stall = 1; req_valid = 1; req_type = 2'd2; req_addr = 32'h88; count = 16'd20;
    pop_valid = 1; pop_type = 2'd2;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: got %b want 0", req_ready); end
    step();
    pop_type = 2'd0;
    step();
    tests++; if (had(2) !== 32'h77 || hot(2) !== 16'd110) begin
      fails++; $display("FAIL stall_hold: got addr %h out %0d want 77 110", had(2), hot(2));
    end
    tests++; if (empty !== 4'b1011) begin fails++; $display("FAIL stall_empty: got %b want 1011", empty); end
    tests++; if (pop_err !== 1'b0) begin fails++; $display("FAIL stall_pop_err: got %b want 0", pop_err); end
    idle();
    pop(2'd2);
    tests++; if (empty[2] !== 1'b1) begin fails++; $display("FAIL stall_single: got %b want 1", empty[2]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2'd0, 32'h1, 5'd1, 16'd1);
    push(2'd1, 32'h2, 5'd2, 16'd2);
    push(2'd2, 32'h3, 5'd3, 16'd3);
    push(2'd3, 32'h4, 5'd4, 16'd4);
    push(2'd0, 32'h5, 5'd5, 16'd5);
    tests++; if (empty !== 4'h0) begin fails++; $display("FAIL mid_loaded: got %b want 0000", empty); end
    reset = 1;
    step();
    reset = 0;
    tests++; if (empty !== 4'hF || full !== 4'h0) begin
      fails++; $display("FAIL mid_reset_flags: got empty %b full %b want 1111 0000", empty, full);
    end
    for (int k = 0; k < 4; k++) begin
      tests++; if (hot(k) !== 16'hFFFF || had(k) !== 32'h0 || hit(k) !== 16'h0 || hram(k) !== 5'h0) begin
        fails++; $display("FAIL mid_reset_head%0d: got out %h addr %h in %h ram %h want ffff 0 0 0",
                          k, hot(k), had(k), hit(k), hram(k));
      end
    end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_dram_push();
    test_wrap();
    test_full();
    test_back_to_back();
    test_pop_err();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_latency_enqueue.md
Name: mem_latency_enqueue

Overview:
- Write side of the timestamped latency FIFOs in the LSU memory-timing path.
- Accepts one memory request per cycle from the LSU and classifies it as L1, L2, DRAM or Shared.
- Stamps each request with an in-time (current count) and an out-time (count + class latency), then pushes it into one of four per-class FIFOs.
- Presents each FIFO head (out-time, in-time, address, RAM slot) to the time-check arbiter and pops on the arbiter's grant.

Parameters:
- DEPTH, 8, entries per class FIFO (power of two, >= 2)
- DEPTH_LOG, 3, log2(DEPTH)
- SIZE_ADDR, 32, request address width
- SIZE_RAM_LOG, 5, RAM slot index width
- SIZE_COUNT, 16, timestamp width
- LAT_L1, 4, L1 latency in cycles
- LAT_L2, 20, L2 latency in cycles
- LAT_DRAM, 100, DRAM latency in cycles
- LAT_SHARED, 2, Shared latency in cycles

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  freezes all state updates
- count  in  SIZE_COUNT  free-running timestamp from the time-check arbiter
- req_valid  in  1  request present
- req_type  in  2  class: 0 = L1, 1 = L2, 2 = DRAM, 3 = Shared
- req_addr  in  SIZE_ADDR  request address
- req_ram_addr  in  SIZE_RAM_LOG  RAM slot holding the request data
- req_ready  out  1  selected class FIFO can accept
- pop_valid  in  1  arbiter grant (RAM_Out)
- pop_type  in  2  class granted
- head_out_time  out  4*SIZE_COUNT  per-class head out-time; class k occupies bits [k*SIZE_COUNT +: SIZE_COUNT]
- head_in_time  out  4*SIZE_COUNT  per-class head in-time
- head_addr  out  4*SIZE_ADDR  per-class head address
- head_ram_addr  out  4*SIZE_RAM_LOG  per-class head RAM slot
- empty  out  4  per-class empty flags
- full  out  4  per-class full flags
- pop_err  out  1  sticky: a pop was issued to an empty class

Behaviour:
- Reset:
  - all pointers and occupancy counters cleared; empty = 4'hF; full = 0; pop_err = 0.
  - every head_out_time = all-ones sentinel; head_in_time, head_addr and head_ram_addr = 0.
  - A reset asserted mid-operation discards all queued entries in the same edge.
- req_ready is combinational: ~full[req_type] & ~stall.
- Push:
  - Fires when req_valid & req_ready.
  - in_time = count.
  - out_time = (count + LAT_class) mod 2^SIZE_COUNT. Wrap-around is intentional; the arbiter's count wraps identically.
  - A computed out_time equal to the all-ones sentinel is stored as sentinel-1, one cycle early.
- Pop:
  - Fires when pop_valid & ~stall.
  - Removes the head of class pop_type.
  - A pop to an empty class leaves all state unchanged and sets pop_err (cleared only by reset).
- Latency:
  - A pushed entry reaches the head outputs on the cycle after the push edge when the FIFO was empty.
  - There is no same-cycle bypass.
  - After a pop, the next entry is visible on the cycle after the pop edge.
- Head outputs are driven from registered storage at the read pointer. When empty, head_out_time = sentinel and the other head fields hold 0.
- Simultaneous push and pop:
  - Same class: both take effect and occupancy is unchanged.
  - Class full: push is refused (req_ready = 0); no push-through-pop.
  - Different classes: independent.
- Full/empty come from per-class occupancy counters of width DEPTH_LOG+1. Pointers wrap modulo DEPTH.
- Stall high: no push (req_ready = 0), no pop, no pop_err update; outputs hold.
- Per-class order is strict FIFO. Ordering between classes is the arbiter's concern.

Decomposition:
- Shared package `mem_timing_pkg`:
  - class encodings MT_L1 = 0, MT_L2 = 1, MT_DRAM = 2, MT_SHARED = 3.
  - SIZE_COUNT, SIZE_RAM_LOG.
  - the all-ones out-time sentinel constant.
  - a latency lookup function indexed by class.
- One sub-module, `ts_fifo`: a single-class timestamped FIFO holding {out_time, in_time, addr, ram_addr}. It has push/pop/full/empty/head outputs and the sentinel-on-empty behaviour, and is instantiated four times.
- Top level holds class decode, timestamp arithmetic, sentinel clamp and pop_err.

Test Plan:
- After reset, push type 2 (DRAM) at count = 50, addr 0x1000, ram 3 -> next cycle: empty[2] = 0, head_out_time[2] = 150, head_in_time[2] = 50, head_ram_addr[2] = 3.
- Push L1 at count = 16'hFFFE -> out_time = 16'h0002 (wrap). Push DRAM at count = 16'hFF9B -> the sum equals the sentinel, so stored out_time = 16'hFFFE.
- Push 8 L2 entries -> full[1] = 1, req_ready = 0 for type 1 while type 0 stays ready. Pop type 1 -> next cycle full[1] = 0 and head advances to the second entry.
- Same-cycle push and pop on Shared with 3 entries -> occupancy stays 3, pop order preserved (addrs A, B, C, D in push order).
- Pop type 0 while empty -> pop_err = 1 and no pointer change; pop_err stays 1 until reset.
- Stall high with req_valid = 1 and pop_valid = 1 -> no state change; after reset mid-queue (5 entries) -> all empty = 1 and head_out_time = 16'hFFFF on all classes.
